// File: rtl/csm_dual_port_mem.sv
// rtl/csm_dual_port_mem.sv - two-port shared register-file memory with per-address hold table
module csm_dual_port_mem #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       a_req,
   input  logic [2:0]                 a_op,
   input  logic [ADDR_W-1:0]          a_addr,
   input  logic [DATA_W-1:0]          a_wdata,
   output logic                       a_ack,
   output logic                       a_err,
   output logic [DATA_W-1:0]          a_rdata,
   input  logic                       b_req,
   input  logic [2:0]                 b_op,
   input  logic [ADDR_W-1:0]          b_addr,
   input  logic [DATA_W-1:0]          b_wdata,
   output logic                       b_ack,
   output logic                       b_err,
   output logic [DATA_W-1:0]          b_rdata,
   output logic [2*(2**ADDR_W)-1:0]   owner
);

   localparam int DEPTH = 2**ADDR_W;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_RD   = 3'b001;
   localparam logic [2:0] OP_WR   = 3'b010;
   localparam logic [2:0] OP_HOLD = 3'b011;
   localparam logic [2:0] OP_REL  = 3'b100;

   localparam logic [1:0] OWN_FREE = 2'b00;
   localparam logic [1:0] OWN_A    = 2'b01;
   localparam logic [1:0] OWN_B    = 2'b10;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [1:0]        own_q [DEPTH];
   logic [1:0]        own_d [DEPTH];

   logic              a_ack_q, a_ack_d, a_err_q, a_err_d;
   logic              b_ack_q, b_ack_d, b_err_q, b_err_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

   logic [1:0] a_own, b_own;
   logic       a_valid, b_valid, a_perm, b_perm, same_addr;

   always_comb begin
      mem_d     = mem_q;
      own_d     = own_q;
      a_ack_d   = 1'b0;
      a_err_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_ack_d   = 1'b0;
      b_err_d   = 1'b0;
      b_rdata_d = b_rdata_q;

      a_valid   = a_req && (a_op != OP_NOP);
      b_valid   = b_req && (b_op != OP_NOP);
      a_own     = own_q[a_addr];
      b_own     = own_q[b_addr];
      a_perm    = (a_own == OWN_FREE) || (a_own == OWN_A);
      b_perm    = (b_own == OWN_FREE) || (b_own == OWN_B);
      same_addr = (a_addr == b_addr);

      // B is evaluated first; on a shared address A has priority, so B
      // backs off explicitly where both would otherwise succeed.
      if (b_valid) begin
         b_ack_d = 1'b1;
         case (b_op)
            OP_RD: begin
               if (b_perm) b_rdata_d = mem_q[b_addr];
               else        b_err_d   = 1'b1;
            end
            OP_WR: begin
               if (b_perm && !(a_valid && same_addr && (a_op == OP_WR) && a_perm))
                  mem_d[b_addr] = b_wdata;
               else
                  b_err_d = 1'b1;
            end
            OP_HOLD: begin
               if ((b_own == OWN_FREE) && !(a_valid && same_addr && (a_op == OP_HOLD)))
                  own_d[b_addr] = OWN_B;
               else if (b_own != OWN_B)
                  b_err_d = 1'b1;
            end
            OP_REL: begin
               if (b_own == OWN_B) own_d[b_addr] = OWN_FREE;
               else                b_err_d       = 1'b1;
            end
            default: b_err_d = 1'b1;
         endcase
      end

      if (a_valid) begin
         a_ack_d = 1'b1;
         case (a_op)
            OP_RD: begin
               if (a_perm) a_rdata_d = mem_q[a_addr];
               else        a_err_d   = 1'b1;
            end
            OP_WR: begin
               if (a_perm) mem_d[a_addr] = a_wdata;
               else        a_err_d       = 1'b1;
            end
            OP_HOLD: begin
               if (a_own == OWN_FREE)  own_d[a_addr] = OWN_A;
               else if (a_own != OWN_A) a_err_d      = 1'b1;
            end
            OP_REL: begin
               if (a_own == OWN_A) own_d[a_addr] = OWN_FREE;
               else                a_err_d       = 1'b1;
            end
            default: a_err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
            own_q[i] <= OWN_FREE;
         end
         a_ack_q   <= 1'b0;
         a_err_q   <= 1'b0;
         a_rdata_q <= '0;
         b_ack_q   <= 1'b0;
         b_err_q   <= 1'b0;
         b_rdata_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
            own_q[i] <= own_d[i];
         end
         a_ack_q   <= a_ack_d;
         a_err_q   <= a_err_d;
         a_rdata_q <= a_rdata_d;
         b_ack_q   <= b_ack_d;
         b_err_q   <= b_err_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   assign a_ack   = a_ack_q;
   assign a_err   = a_err_q;
   assign a_rdata = a_rdata_q;
   assign b_ack   = b_ack_q;
   assign b_err   = b_err_q;
   assign b_rdata = b_rdata_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_owner
      assign owner[2*g+1:2*g] = own_q[g];
   end

endmodule

// File: tb/tb_csm_dual_port_mem.sv
// tb/tb_csm_dual_port_mem.sv - scoreboard bench for csm_dual_port_mem
module tb_csm_dual_port_mem;

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] RD   = 3'b001;
   localparam logic [2:0] WR   = 3'b010;
   localparam logic [2:0] HOLD = 3'b011;
   localparam logic [2:0] REL  = 3'b100;
   localparam logic [2:0] ILL  = 3'b111;

   typedef struct packed {
      logic       ack;
      logic       err;
      logic [7:0] rd;
   } rsp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       a_req = 1'b0, b_req = 1'b0;
   logic [2:0] a_op = 3'b0, b_op = 3'b0;
   logic [1:0] a_addr = 2'b0, b_addr = 2'b0;
   logic [7:0] a_wdata = 8'h0, b_wdata = 8'h0;
   logic       a_ack, a_err, b_ack, b_err;
   logic [7:0] a_rdata, b_rdata;
   logic [7:0] owner;

   int   n_checks = 0;
   int   n_errors = 0;
   int   step_no = 0;
   rsp_t qa[$];
   rsp_t qb[$];
   logic a_set = 1'b0, b_set = 1'b0;
   logic [7:0] a_last = 8'h00, b_last = 8'h00;

   csm_dual_port_mem #(.DATA_W(8), .ADDR_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", tag, step_no, obs, exp);
      end
   endtask

   task automatic req_a(input logic [2:0] op, input logic [1:0] addr, input logic [7:0] wd,
                        input logic e_err, input logic [7:0] e_rd);
      rsp_t r;
      a_req = 1'b1; a_op = op; a_addr = addr; a_wdata = wd;
      if (op == RD && !e_err) a_last = e_rd;
      r.ack = (op != NOP);
      r.err = e_err;
      r.rd  = a_last;
      qa.push_back(r);
      a_set = 1'b1;
   endtask

   task automatic req_b(input logic [2:0] op, input logic [1:0] addr, input logic [7:0] wd,
                        input logic e_err, input logic [7:0] e_rd);
      rsp_t r;
      b_req = 1'b1; b_op = op; b_addr = addr; b_wdata = wd;
      if (op == RD && !e_err) b_last = e_rd;
      r.ack = (op != NOP);
      r.err = e_err;
      r.rd  = b_last;
      qb.push_back(r);
      b_set = 1'b1;
   endtask

   task automatic step();
      rsp_t ea, eb;
      if (!a_set) begin ea = '{1'b0, 1'b0, a_last}; qa.push_back(ea); end
      if (!b_set) begin eb = '{1'b0, 1'b0, b_last}; qb.push_back(eb); end
      @(posedge clk);
      @(negedge clk);
      step_no++;
      check("qa_depth", qa.size(), 1);
      check("qb_depth", qb.size(), 1);
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         check("a_ack", a_ack, ea.ack);
         check("a_err", a_err, ea.err);
         check("a_rdata", a_rdata, ea.rd);
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         check("b_ack", b_ack, eb.ack);
         check("b_err", b_err, eb.err);
         check("b_rdata", b_rdata, eb.rd);
      end
      a_req = 1'b0; a_op = NOP; b_req = 1'b0; b_op = NOP;
      a_set = 1'b0; b_set = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_a_ack", a_ack, 0);
      check("rst_b_ack", b_ack, 0);
      check("rst_a_err", a_err, 0);
      check("rst_b_err", b_err, 0);
      check("rst_a_rdata", a_rdata, 0);
      check("rst_b_rdata", b_rdata, 0);
      check("rst_owner", owner, 8'h00);
      reset_n = 1'b1;
      step();

      // basic write / read back from both ports
      req_a(WR, 2'd2, 8'h5A, 1'b0, 8'h00); step();
      req_a(RD, 2'd2, 8'h00, 1'b0, 8'h5A); step();
      req_b(RD, 2'd2, 8'h00, 1'b0, 8'h5A); step();

      // A holds addr 1, B locked out
      req_a(HOLD, 2'd1, 8'h00, 1'b0, 8'h00); step();
      check("owner_hold1", owner, 8'h04);
      req_b(RD, 2'd1, 8'h00, 1'b1, 8'h00); step();
      req_b(WR, 2'd1, 8'hFF, 1'b1, 8'h00); step();
      check("owner_hold1b", owner, 8'h04);
      req_a(RD, 2'd1, 8'h00, 1'b0, 8'h00); step();
      req_a(HOLD, 2'd1, 8'h00, 1'b0, 8'h00); step();
      req_a(REL, 2'd1, 8'h00, 1'b0, 8'h00); step();
      check("owner_rel1", owner, 8'h00);
      req_b(RD, 2'd1, 8'h00, 1'b0, 8'h00); step();
      req_a(REL, 2'd1, 8'h00, 1'b1, 8'h00); step();

      // write/write collision
      req_a(WR, 2'd3, 8'h11, 1'b0, 8'h00);
      req_b(WR, 2'd3, 8'h22, 1'b1, 8'h00); step();
      req_a(RD, 2'd3, 8'h00, 1'b0, 8'h11);
      req_b(RD, 2'd3, 8'h00, 1'b0, 8'h11); step();

      // hold/hold collision, bad release, illegal op
      req_a(HOLD, 2'd0, 8'h00, 1'b0, 8'h00);
      req_b(HOLD, 2'd0, 8'h00, 1'b1, 8'h00); step();
      check("owner_hold0", owner, 8'h01);
      req_b(REL, 2'd0, 8'h00, 1'b1, 8'h00); step();
      req_a(ILL, 2'd2, 8'h00, 1'b1, 8'h00);
      req_b(WR, 2'd0, 8'h99, 1'b1, 8'h00); step();
      check("owner_hold0b", owner, 8'h01);

      // read + write same address from opposite ports
      req_a(RD, 2'd2, 8'h00, 1'b0, 8'h5A);
      req_b(WR, 2'd2, 8'h77, 1'b0, 8'h00); step();
      req_b(RD, 2'd2, 8'h00, 1'b0, 8'h77); step();

      // hold by B with simultaneous write by A on a free address
      req_a(WR, 2'd3, 8'h33, 1'b0, 8'h00);
      req_b(HOLD, 2'd3, 8'h00, 1'b0, 8'h00); step();
      check("owner_mix", owner, 8'h81);
      req_a(RD, 2'd3, 8'h00, 1'b1, 8'h00);
      req_b(RD, 2'd3, 8'h00, 1'b0, 8'h33); step();
      req_a(NOP, 2'd3, 8'h00, 1'b0, 8'h00);
      req_b(REL, 2'd3, 8'h00, 1'b0, 8'h00); step();
      req_a(REL, 2'd0, 8'h00, 1'b0, 8'h00); step();
      check("owner_free", owner, 8'h00);

      // reset in the middle of a response
      req_a(HOLD, 2'd0, 8'h00, 1'b0, 8'h00); step();
      a_req = 1'b1; a_op = WR; a_addr = 2'd0; a_wdata = 8'hFF;
      @(posedge clk);
      #1;
      a_req = 1'b0; a_op = NOP;
      reset_n = 1'b0;
      #1;
      check("mid_rst_a_ack", a_ack, 0);
      check("mid_rst_a_err", a_err, 0);
      check("mid_rst_a_rdata", a_rdata, 0);
      check("mid_rst_b_rdata", b_rdata, 0);
      check("mid_rst_owner", owner, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      a_last = 8'h00;
      b_last = 8'h00;
      step();
      req_a(RD, 2'd0, 8'h00, 1'b0, 8'h00); step();
      req_b(RD, 2'd2, 8'h00, 1'b0, 8'h00); step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/csm_dual_port_mem.md
Name: csm_dual_port_mem

Overview:
- Concurrent shared memory (CSM) core driven through the CSM BFM. It is the design under test that consumes the tester's A/B read, write, hold and release operations.
- Two independent request ports (A, B) share a small register-file memory.
- A per-address hold table gives one port exclusive access to an address. Conflicting accesses from the other port are rejected with an error response.
- Every request gets a registered response exactly one cycle later.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W = 4 words.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request valid, sampled every cycle.
- a_op  in  3  port A opcode: 000 NOP, 001 READ, 010 WRITE, 011 HOLD, 100 RELEASE, 101-111 illegal.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data (WRITE only; ignored otherwise).
- a_ack  out  1  port A response strobe, one cycle after the accepted request.
- a_err  out  1  port A request rejected; valid with a_ack.
- a_rdata  out  DATA_W  port A read data; valid with a_ack on a successful READ.
- b_req, b_op, b_addr, b_wdata, b_ack, b_err, b_rdata: identical set for port B.
- owner  out  2*DEPTH  hold table; 2 bits per address (00 FREE, 01 A, 10 B); address i at bits [2i+1:2i].

Behaviour:
- Reset (async assert, sync release):
  - all memory words = 0, all owners = FREE.
  - a_ack = b_ack = 0, a_err = b_err = 0, a_rdata = b_rdata = 0.
- Requests:
  - A request is any cycle with req = 1 and op != NOP. req = 1 with NOP produces no ack.
  - No back-pressure; a port may issue a new request every cycle.
- Latency:
  - ack/err/rdata registered, asserted in cycle N+1 for a request in cycle N, held for one cycle.
  - rdata holds its last value when not acked.
- Access rule: a port P may access address X if owner[X] is FREE or P; otherwise X is held by the other port.
- READ: permitted -> rdata = mem[X] sampled at cycle N (pre-write value), err = 0. Held by other -> err = 1, rdata unchanged.
- WRITE: permitted -> mem[X] = wdata at end of cycle N, err = 0. Held by other -> no write, err = 1.
- HOLD:
  - owner FREE -> owner = P, err = 0.
  - owner already P -> no change, err = 0.
  - held by other -> err = 1.
- RELEASE: owner = P -> owner = FREE, err = 0. Owner FREE or other -> err = 1, no change.
- Illegal opcode: err = 1, no state change.
- Simultaneous A and B requests to different addresses: fully independent.
- Simultaneous requests to the same address, owner is evaluated on pre-cycle state:
  - A WRITE + B WRITE, both permitted: A's data is written, A err = 0, B err = 1 (collision).
  - READ + WRITE from opposite ports, both permitted: reader gets old data, write commits, both err = 0.
  - A HOLD + B HOLD on FREE: A takes ownership, B err = 1.
  - HOLD by one port + READ/WRITE by the other on FREE: both succeed; the access uses pre-hold permission and the hold then takes effect.
  - READ + READ: both succeed with the same data.
- Ownership changes take effect for requests in cycle N+1 onward.
- Reset mid-operation: pending responses are discarded; no ack in the cycle after reset release unless a new request arrives.

Test Plan:
- Reset, then A WRITE addr 2 data 0x5A, next cycle A READ addr 2 -> A ack with err = 0, then rdata = 0x5A one cycle after the read; B READ addr 2 -> 0x5A.
- A HOLD addr 1, then B READ addr 1 and B WRITE addr 1 data 0xFF -> both B err = 1; mem[1] stays 0; owner[3:2] = 01.
- A HOLD addr 1, A RELEASE addr 1, B READ addr 1 -> all err = 0; owner[3:2] = 00; B rdata = 0x00.
- Same-cycle A WRITE addr 3 data 0x11 and B WRITE addr 3 data 0x22 -> A err = 0, B err = 1, later read of addr 3 = 0x11.
- Same-cycle A HOLD and B HOLD on addr 0 -> A err = 0, B err = 1, owner[1:0] = 01. B RELEASE addr 0 -> err = 1. Illegal op 111 on A -> err = 1.
- A WRITE addr 0 data 0xFF on cycle N, assert reset_n = 0 on cycle N+1 -> all outputs 0 immediately, mem[0] reads 0x00 after reset release.
